// File: rtl/xgemac_rx_pkt_reader.sv
// Store-and-forward RX reader: buffers MAC words, forwards only complete error-free frames.
// Latency: first word out 2 edges after its eop is written; backpressure: out_* hold while !out_ready, ren drops near full.
module xgemac_rx_pkt_reader #(
    parameter int ADDR_WIDTH = 9,
    parameter int MIN_FREE   = 4,
    parameter int CNT_WIDTH  = 32
) (
    input  logic                 clk_156m25,
    input  logic                 reset_156m25,
    input  logic                 pkt_rx_avail,
    output logic                 pkt_rx_ren,
    input  logic                 pkt_rx_val,
    input  logic [63:0]          pkt_rx_data,
    input  logic                 pkt_rx_sop,
    input  logic                 pkt_rx_eop,
    input  logic [2:0]           pkt_rx_mod,
    input  logic                 pkt_rx_err,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [63:0]          out_data,
    output logic                 out_sop,
    output logic                 out_eop,
    output logic [2:0]           out_mod,
    output logic [CNT_WIDTH-1:0] cnt_frames_ok,
    output logic [CNT_WIDTH-1:0] cnt_drop_err,
    output logic [CNT_WIDTH-1:0] cnt_drop_ovf
);

    localparam int PW = ADDR_WIDTH + 1;
    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam logic [PW-1:0] DEPTH_P = PW'(DEPTH);
    localparam logic [PW-1:0] ONE_P = PW'(1);
    localparam logic [PW-1:0] MIN_FREE_P = PW'(MIN_FREE);

    typedef struct packed {
        logic        sop;
        logic        eop;
        logic [2:0]  mod;
        logic [63:0] data;
    } word_t;

    typedef enum logic [1:0] {S_IDLE, S_FRAME, S_DROP} state_t;

    state_t                 state_q, state_d;
    logic [PW-1:0]          wr_q, wr_d, commit_q, commit_d, rd_q, rd_d;
    logic                   ren_q, ren_d;
    logic                   s1_vld_q, s1_vld_d;
    logic                   out_vld_q, out_vld_d;
    word_t                  out_word_q, out_word_d;
    logic [CNT_WIDTH-1:0]   cnt_ok_q, cnt_ok_d, cnt_err_q, cnt_err_d, cnt_ovf_q, cnt_ovf_d;

    word_t                  mem_q [DEPTH];
    word_t                  s1_dat_q;
    word_t                  wdat;
    logic                   we, rd_en, out_adv, take_word, ok_inc, ovf_inc;
    logic [1:0]             err_add;
    logic [ADDR_WIDTH-1:0]  waddr;
    logic [PW-1:0]          free_wr, free_cm, wbase, wfree;

    function automatic logic [CNT_WIDTH-1:0] sat_add(input logic [CNT_WIDTH-1:0] c,
                                                     input logic [1:0] a);
        logic [CNT_WIDTH:0] s;
        s = {1'b0, c} + {{(CNT_WIDTH-1){1'b0}}, a};
        return s[CNT_WIDTH] ? '1 : s[CNT_WIDTH-1:0];
    endfunction

    assign free_wr = DEPTH_P - (wr_q - rd_q);
    assign free_cm = DEPTH_P - (commit_q - rd_q);

    // A sop always (re)starts at commit_ptr, discarding any unterminated frame behind it.
    always_comb begin
        state_d   = state_q;
        wr_d      = wr_q;
        commit_d  = commit_q;
        we        = 1'b0;
        err_add   = 2'd0;
        ok_inc    = 1'b0;
        ovf_inc   = 1'b0;
        wdat      = {pkt_rx_sop, pkt_rx_eop, pkt_rx_mod, pkt_rx_data};
        wbase     = pkt_rx_sop ? commit_q : wr_q;
        wfree     = pkt_rx_sop ? free_cm : free_wr;
        waddr     = wbase[ADDR_WIDTH-1:0];
        take_word = pkt_rx_val & (pkt_rx_sop | (state_q == S_FRAME));

        if (take_word) begin
            if (pkt_rx_sop && state_q == S_FRAME) begin
                err_add = 2'd1;
            end
            if (wfree == '0) begin
                ovf_inc = 1'b1;
                wr_d    = commit_q;
                state_d = pkt_rx_eop ? S_IDLE : S_DROP;
            end else begin
                we = 1'b1;
                if (!pkt_rx_eop) begin
                    wr_d    = wbase + ONE_P;
                    state_d = S_FRAME;
                end else if (pkt_rx_err) begin
                    wr_d    = commit_q;
                    err_add = err_add + 2'd1;
                    state_d = S_IDLE;
                end else begin
                    wr_d     = wbase + ONE_P;
                    commit_d = wbase + ONE_P;
                    ok_inc   = 1'b1;
                    state_d  = S_IDLE;
                end
            end
        end else if (pkt_rx_val && state_q == S_DROP && pkt_rx_eop) begin
            state_d = S_IDLE;
        end
    end

    // When nothing committed remains, keep pulling so an oversize frame overflows instead of stalling.
    always_comb begin
        ren_d      = pkt_rx_avail & ((free_wr >= MIN_FREE_P) | (rd_q == commit_q));
        out_adv    = ~out_vld_q | out_ready;
        rd_en      = (rd_q != commit_q) & (~s1_vld_q | out_adv);
        rd_d       = rd_en ? rd_q + ONE_P : rd_q;
        s1_vld_d   = rd_en | (s1_vld_q & ~out_adv);
        out_vld_d  = out_adv ? s1_vld_q : out_vld_q;
        out_word_d = (out_adv & s1_vld_q) ? s1_dat_q : out_word_q;
        cnt_ok_d   = sat_add(cnt_ok_q, {1'b0, ok_inc});
        cnt_err_d  = sat_add(cnt_err_q, err_add);
        cnt_ovf_d  = sat_add(cnt_ovf_q, {1'b0, ovf_inc});
    end

    always_ff @(posedge clk_156m25) begin
        if (reset_156m25) begin
            state_q    <= S_IDLE;
            wr_q       <= '0;
            commit_q   <= '0;
            rd_q       <= '0;
            ren_q      <= 1'b0;
            s1_vld_q   <= 1'b0;
            out_vld_q  <= 1'b0;
            out_word_q <= '0;
            cnt_ok_q   <= '0;
            cnt_err_q  <= '0;
            cnt_ovf_q  <= '0;
        end else begin
            state_q    <= state_d;
            wr_q       <= wr_d;
            commit_q   <= commit_d;
            rd_q       <= rd_d;
            ren_q      <= ren_d;
            s1_vld_q   <= s1_vld_d;
            out_vld_q  <= out_vld_d;
            out_word_q <= out_word_d;
            cnt_ok_q   <= cnt_ok_d;
            cnt_err_q  <= cnt_err_d;
            cnt_ovf_q  <= cnt_ovf_d;
        end
    end

    always_ff @(posedge clk_156m25) begin
        if (we) begin
            mem_q[waddr] <= wdat;
        end
        if (rd_en) begin
            s1_dat_q <= mem_q[rd_q[ADDR_WIDTH-1:0]];
        end
    end

    assign pkt_rx_ren    = ren_q;
    assign out_valid     = out_vld_q;
    assign out_data      = out_word_q.data;
    assign out_sop       = out_word_q.sop;
    assign out_eop       = out_word_q.eop;
    assign out_mod       = out_word_q.mod;
    assign cnt_frames_ok = cnt_ok_q;
    assign cnt_drop_err  = cnt_err_q;
    assign cnt_drop_ovf  = cnt_ovf_q;

endmodule
